ntt_axil_ctrl_slave: RTL and testbench
======================================

Name: ntt_axil_ctrl_slave

Overview:
AXI4-Lite slave register block on the NTT IP control port at base 0x43C0_0000. It responds to the PS-side initiator.
- Decodes CONTROL, STATUS, IRQ_EN and VERSION registers.
- Issues a one-cycle start pulse and a mode level to the NTT core.
- Tracks busy, done and error.
- Drives the level interrupt that goes to PS IRQ line 0.

Parameters:
C_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
C_ADDR_WIDTH, 4, byte address width; covers 4 word registers.
C_VERSION, 32'h0001_0000, constant returned by the VERSION register.
C_IRQ_EN_RST, 1'b1, reset value of IRQ_EN.enable.

Ports:
ACLK  in  1  single clock for the bus and the core interface.
ARESET  in  1  asynchronous active-high reset.
S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  C_ADDR_WIDTH  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
core_start  out  1  one-cycle start pulse to the NTT core.
core_mode  out  1  0 = NTT, 1 = INTT; held stable while busy.
core_busy  in  1  core running.
core_done  in  1  one-cycle completion pulse from the core.
irq  out  1  level interrupt = STATUS.DONE & IRQ_EN.enable.

Behaviour:
- Reset (ARESET=1, async): all READY/VALID outputs, RDATA, core_start, core_mode, irq, DONE, ERROR and busy_q are 0; IRQ_EN = C_IRQ_EN_RST.
- Register map (word index ADDR[3:2]; ADDR[1:0] ignored):
  - 0x00 CONTROL: bit0 START (write-1 action, reads 0); bit1 MODE (R/W).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERROR (W1C).
  - 0x08 IRQ_EN: bit0 (R/W).
  - 0x0C VERSION: RO; writes are ignored.
  - Unused bits read 0.
- Write channel:
  - AW and W are accepted independently; each READY is high while its holding register is empty and BVALID=0.
  - Once both address and data are held, the register update happens on the next edge and BVALID is set in that same edge.
  - BVALID holds until BREADY; the holding registers free at that point.
  - Minimum latency: AW+W accepted on cycle N, BVALID on cycle N+1.
  - WSTRB[0]=0 means no effect on register bits [7:0]; all defined bits lie in byte 0.
- Read channel:
  - ARREADY=1 when RVALID=0.
  - On AR handshake, RDATA is registered and RVALID rises the next cycle; it holds until RREADY.
  - At most one read is outstanding.
- Any write to CONTROL clears DONE. This is the PS acknowledge.
- START=1 write:
  - If (busy_q | core_busy)=0: MODE is latched to core_mode, core_start is pulsed for exactly 1 cycle (the cycle after the write edge), and busy_q is set.
  - Otherwise: no pulse, MODE is unchanged, ERROR is set.
- MODE write with START=0 while busy is ignored; core_mode stays frozen.
- core_done=1: busy_q is cleared and DONE is set.
- STATUS.BUSY = busy_q | core_busy.
- Simultaneous events:
  - core_done in the same cycle as a DONE-clearing write: set wins, so DONE=1.
  - core_done in the same cycle as START: start is treated as busy and ERROR is set.
- irq is combinational from the flops (no extra latency beyond the DONE flop). It is deasserted the cycle after the acknowledging write.
- Reset mid-transaction: pending VALIDs drop immediately. The master must restart the transaction. No pulse is issued.

Test Plan:
1. After reset, read 0x00/0x04/0x08/0x0C -> 0x0, 0x0, 0x1, 0x0001_0000; BRESP and RRESP are 0.
2. Write 0x00=0x3 (AW and W same cycle) -> BVALID next cycle; core_start high exactly 1 cycle; core_mode=1; STATUS reads 0x1.
3. Pulse core_done -> STATUS=0x2 and irq=1. Then write 0x00=0x0 -> irq=0 and STATUS=0x0.
4. Write 0x00=0x1 while core_busy=1 -> no core_start; STATUS bit2=1. Then write 0x04=0x4 -> ERROR cleared.
5. Present W 3 cycles before AW, and hold BREADY=0 for 5 cycles -> a single write occurs; BVALID stays high; AWREADY and WREADY stay 0 until B completes.
6. Write 0x08=0x0, then pulse core_done -> DONE=1 and irq=0. Then write 0x08=0x1 -> irq=1 the next cycle.
7. Pulse core_done in the same cycle as the write of 0x00=0x0 -> DONE remains 1.

Source files
------------

// File: rtl/ntt_axil_ctrl_slave_if.sv
// AXI4-Lite bundle for the NTT control port.
// Latency: none; wires only.
// Backpressure: standard AXI valid/ready on AW, W, B, AR and R.
// Ports: AW/W/B write channels and AR/R read channels. The slave modport is
// used by the register block and the master modport by the PS-side initiator.
interface ntt_axil_ctrl_slave_if #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/ntt_axil_ctrl_slave.sv
// AXI4-Lite control/status register block for the NTT core (CONTROL, STATUS, IRQ_EN, VERSION).
// Latency: write commits on the edge that completes AW+W (BVALID next cycle); read data one cycle after AR.
// Backpressure: AW/W stall while their holder is full or BVALID is pending; AR stalls while RVALID is pending.
// Ports: ACLK/ARESET (async, active high); s_axi slave bundle; core_start/core_mode to the core;
// core_busy/core_done from the core; irq = STATUS.DONE & IRQ_EN.enable.
module ntt_axil_ctrl_slave #(
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_ADDR_WIDTH = 4,
    parameter logic [31:0] C_VERSION    = 32'h0001_0000,
    parameter logic        C_IRQ_EN_RST = 1'b1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    ntt_axil_ctrl_slave_if.slave s_axi,
    output logic                 core_start,
    output logic                 core_mode,
    input  logic                 core_busy,
    input  logic                 core_done,
    output logic                 irq
);
    localparam logic [1:0] IDX_CONTROL = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
    localparam logic [1:0] IDX_IRQ_EN  = 2'd2;
    localparam logic [1:0] IDX_VERSION = 2'd3;

    // write holding registers
    logic       aw_held, w_held;
    logic [1:0] aw_idx_q;
    logic [2:0] w_data_q;
    logic       w_strb0_q;
    logic       bvalid_q;

    // read channel
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // register state
    logic done_q, error_q, busy_q, irq_en_q, mode_q, start_q;

    logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic       wr_fire;
    logic [1:0] wr_idx;
    logic [2:0] wr_data;
    logic       wr_strb0;
    logic       busy_any;
    logic       ctrl_wr, stat_wr, irqen_wr;
    logic       start_req, start_ok, start_err, mode_wr;
    logic [31:0] rd_mux;

    assign s_axi.S_AXI_AWREADY = ~ARESET & ~aw_held & ~bvalid_q;
    assign s_axi.S_AXI_WREADY  = ~ARESET & ~w_held  & ~bvalid_q;
    assign s_axi.S_AXI_ARREADY = ~ARESET & ~rvalid_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign aw_hs = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID  & s_axi.S_AXI_WREADY;
    assign ar_hs = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign b_hs  = bvalid_q & s_axi.S_AXI_BREADY;
    assign r_hs  = rvalid_q & s_axi.S_AXI_RREADY;

    // Bypass the holders so an AW+W pair arriving together commits on its accept edge.
    always_comb begin
        wr_idx   = aw_held ? aw_idx_q  : s_axi.S_AXI_AWADDR[3:2];
        wr_data  = w_held  ? w_data_q  : s_axi.S_AXI_WDATA[2:0];
        wr_strb0 = w_held  ? w_strb0_q : s_axi.S_AXI_WSTRB[0];
    end

    assign wr_fire  = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid_q;
    assign busy_any = busy_q | core_busy;

    assign ctrl_wr  = wr_fire & (wr_idx == IDX_CONTROL);
    assign stat_wr  = wr_fire & (wr_idx == IDX_STATUS)  & wr_strb0;
    assign irqen_wr = wr_fire & (wr_idx == IDX_IRQ_EN)  & wr_strb0;

    // A completion arriving with START is treated as still busy: the start is refused.
    assign start_req = ctrl_wr & wr_strb0 & wr_data[0];
    assign start_ok  = start_req & ~busy_any & ~core_done;
    assign start_err = start_req & ~start_ok;
    // MODE is frozen while busy and on any refused start.
    assign mode_wr   = ctrl_wr & wr_strb0 & ~busy_any & ~start_err;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx_q  <= 2'd0;
            w_data_q  <= 3'd0;
            w_strb0_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_idx_q <= s_axi.S_AXI_AWADDR[3:2];
            if (w_hs) begin
                w_data_q  <= s_axi.S_AXI_WDATA[2:0];
                w_strb0_q <= s_axi.S_AXI_WSTRB[0];
            end
            // holders stay full until the response is taken, which also blocks new AW/W
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
            if (wr_fire)   bvalid_q <= 1'b1;
            else if (b_hs) bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            irq_en_q <= C_IRQ_EN_RST;
            mode_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            start_q <= start_ok;
            if (mode_wr)  mode_q   <= wr_data[1];
            if (irqen_wr) irq_en_q <= wr_data[0];
            // a core completion overrides a same-cycle acknowledge
            if (core_done)                            done_q <= 1'b1;
            else if (ctrl_wr | (stat_wr & wr_data[1])) done_q <= 1'b0;
            if (start_err)                   error_q <= 1'b1;
            else if (stat_wr & wr_data[2])   error_q <= 1'b0;
            if (start_ok)       busy_q <= 1'b1;
            else if (core_done) busy_q <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (s_axi.S_AXI_ARADDR[3:2])
            IDX_CONTROL: rd_mux = {30'd0, mode_q, 1'b0};
            IDX_STATUS:  rd_mux = {29'd0, error_q, done_q, busy_any};
            IDX_IRQ_EN:  rd_mux = {31'd0, irq_en_q};
            IDX_VERSION: rd_mux = C_VERSION;
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    assign core_start = start_q;
    assign core_mode  = mode_q;
    assign irq        = done_q & irq_en_q;

    // address byte offset and upper data/strobe bits carry no defined register state
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                           s_axi.S_AXI_WDATA[C_DATA_WIDTH-1:3],
                           s_axi.S_AXI_WSTRB[C_DATA_WIDTH/8-1:1]};
endmodule

// File: tb/tb_ntt_axil_ctrl_slave.sv
`timescale 1ns/1ps
module tb_ntt_axil_ctrl_slave;
    logic tb_ACLK;
    logic tb_ARESET;
    logic core_start, core_mode, core_busy, core_done, irq;

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    ntt_axil_ctrl_slave_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) s_axi ();

    ntt_axil_ctrl_slave #(
        .C_DATA_WIDTH(32), .C_ADDR_WIDTH(4),
        .C_VERSION(32'h0001_0000), .C_IRQ_EN_RST(1'b1)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(tb_ARESET), .s_axi(s_axi),
        .core_start(core_start), .core_mode(core_mode),
        .core_busy(core_busy), .core_done(core_done), .irq(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    logic [31:0] rd_q[$];
    logic [3:0]  rd_addr_q[$];
    logic [1:0]  b_q[$];
    logic [31:0] mon_exp;
    logic [3:0]  mon_addr;
    logic [1:0]  mon_bexp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
    endtask

    // Write with AW and W presented together; lat = cycles from accept to BVALID.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                             input logic with_done, output int lat);
        bit aw_acc, w_acc, bdone;
        int n;
        aw_acc = 0; w_acc = 0; bdone = 0; n = 0; lat = -1;
        b_q.push_back(2'b00);
        s_axi.S_AXI_AWADDR = a;  s_axi.S_AXI_AWVALID = 1'b1;
        s_axi.S_AXI_WDATA  = d;  s_axi.S_AXI_WSTRB   = st; s_axi.S_AXI_WVALID = 1'b1;
        if (with_done) core_done = 1'b1;
        while (!(aw_acc && w_acc) && n < 20) begin
            @(negedge tb_ACLK);
            if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY) aw_acc = 1;
            if (s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY)   w_acc = 1;
            step();
            core_done = 1'b0;
            if (aw_acc) s_axi.S_AXI_AWVALID = 1'b0;
            if (w_acc)  s_axi.S_AXI_WVALID  = 1'b0;
            n++;
        end
        if (!(aw_acc && w_acc)) chk("wr_accept_timeout", {30'd0, aw_acc, w_acc}, 32'd3);
        n = 0;
        while (!bdone && n < 20) begin
            @(negedge tb_ACLK);
            if (s_axi.S_AXI_BVALID) begin
                if (lat < 0) lat = n;
                if (s_axi.S_AXI_BREADY) bdone = 1;
            end
            step();
            n++;
        end
        if (!bdone) chk("b_timeout", {31'd0, s_axi.S_AXI_BVALID}, 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        bit acc;
        int n;
        acc = 0; n = 0;
        rd_q.push_back(exp);
        rd_addr_q.push_back(a);
        s_axi.S_AXI_ARADDR = a; s_axi.S_AXI_ARVALID = 1'b1;
        while (!acc && n < 20) begin
            @(negedge tb_ACLK);
            if (s_axi.S_AXI_ARREADY) acc = 1;
            step();
            n++;
        end
        s_axi.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (rd_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (rd_q.size() != 0) begin
            chk("rd_timeout", rd_q.size(), 32'd0);
            rd_q.delete();
            rd_addr_q.delete();
        end
    endtask

    initial begin
        int lat, s0, n;
        bit acc;
        tb_ARESET = 1'b1;
        core_busy = 1'b0; core_done = 1'b0;
        s_axi.S_AXI_AWADDR = '0; s_axi.S_AXI_AWVALID = 1'b0;
        s_axi.S_AXI_WDATA  = '0; s_axi.S_AXI_WSTRB   = '0; s_axi.S_AXI_WVALID = 1'b0;
        s_axi.S_AXI_BREADY = 1'b1;
        s_axi.S_AXI_ARADDR = '0; s_axi.S_AXI_ARVALID = 1'b0;
        s_axi.S_AXI_RREADY = 1'b1;

        // scoreboard monitor: pops expected responses on each R/B handshake
        fork
            forever begin
                @(negedge tb_ACLK);
                if (core_start === 1'b1) start_cnt++;
                if (s_axi.S_AXI_RVALID && s_axi.S_AXI_RREADY) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected", {31'd0, s_axi.S_AXI_RVALID}, 32'd0);
                    end else begin
                        mon_exp  = rd_q.pop_front();
                        mon_addr = rd_addr_q.pop_front();
                        chk($sformatf("rdata@0x%0h", mon_addr), s_axi.S_AXI_RDATA, mon_exp);
                        chk("rresp", {30'd0, s_axi.S_AXI_RRESP}, 32'd0);
                    end
                end
                if (s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY) begin
                    if (b_q.size() == 0) begin
                        chk("b_unexpected", {31'd0, s_axi.S_AXI_BVALID}, 32'd0);
                    end else begin
                        mon_bexp = b_q.pop_front();
                        chk("bresp", {30'd0, s_axi.S_AXI_BRESP}, {30'd0, mon_bexp});
                    end
                end
            end
        join_none

        // reset state
        #3;
        chk("reset_outputs", {24'd0, s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY,
                              s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, core_start, core_mode, irq}, 32'd0);
        chk("reset_rdata", s_axi.S_AXI_RDATA, 32'd0);
        step(); step();
        tb_ARESET = 1'b0;
        step();

        // 1: register map after reset
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h0);
        axi_read(4'h8, 32'h1);
        axi_read(4'hC, 32'h0001_0000);
        axi_read(4'hD, 32'h0001_0000);

        // 2: START + MODE
        s0 = start_cnt;
        axi_write(4'h0, 32'h3, 4'hF, 1'b0, lat);
        chk("b_latency", lat, 32'd0);
        chk("start_pulses", start_cnt - s0, 32'd1);
        chk("core_mode_after_start", {31'd0, core_mode}, 32'd1);
        axi_read(4'h4, 32'h1);
        axi_read(4'h0, 32'h2);

        // 3: completion, interrupt, acknowledge
        pulse_done();
        chk("irq_after_done", {31'd0, irq}, 32'd1);
        axi_read(4'h4, 32'h2);
        axi_write(4'h0, 32'h0, 4'hF, 1'b0, lat);
        chk("irq_after_ack", {31'd0, irq}, 32'd0);
        axi_read(4'h4, 32'h0);

        // 4: start while busy -> error
        core_busy = 1'b1;
        s0 = start_cnt;
        axi_write(4'h0, 32'h1, 4'hF, 1'b0, lat);
        chk("no_start_when_busy", start_cnt - s0, 32'd0);
        axi_read(4'h4, 32'h5);
        axi_write(4'h4, 32'h4, 4'hF, 1'b0, lat);
        axi_read(4'h4, 32'h1);
        core_busy = 1'b0;
        axi_read(4'h4, 32'h0);

        // 5: W ahead of AW, B held off
        s_axi.S_AXI_BREADY = 1'b0;
        s_axi.S_AXI_WDATA = 32'h2; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 20) begin
            @(negedge tb_ACLK);
            if (s_axi.S_AXI_WREADY) acc = 1;
            step();
            n++;
        end
        s_axi.S_AXI_WVALID = 1'b0;
        chk("w_alone_accepted", {31'd0, acc}, 32'd1);
        step(); step();
        b_q.push_back(2'b00);
        s_axi.S_AXI_AWADDR = 4'h0; s_axi.S_AXI_AWVALID = 1'b1;
        @(negedge tb_ACLK);
        chk("aw_ready_late", {31'd0, s_axi.S_AXI_AWREADY}, 32'd1);
        step();
        s_axi.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            chk($sformatf("b_hold%0d", i), {29'd0, s_axi.S_AXI_BVALID, s_axi.S_AXI_AWREADY,
                                            s_axi.S_AXI_WREADY}, 32'h4);
            step();
        end
        s_axi.S_AXI_BREADY = 1'b1;
        step();
        @(negedge tb_ACLK);
        chk("ready_after_b", {30'd0, s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY}, 32'h3);
        chk("b_queue_drained", b_q.size(), 32'd0);
        step();
        axi_read(4'h0, 32'h2);
        chk("core_mode_single_write", {31'd0, core_mode}, 32'd1);

        // 6: IRQ_EN masking, strobe gating
        axi_write(4'h8, 32'h0, 4'hE, 1'b0, lat);
        axi_read(4'h8, 32'h1);
        axi_write(4'h8, 32'h0, 4'hF, 1'b0, lat);
        axi_read(4'h8, 32'h0);
        pulse_done();
        chk("irq_masked", {31'd0, irq}, 32'd0);
        axi_read(4'h4, 32'h2);
        axi_write(4'h8, 32'h1, 4'hF, 1'b0, lat);
        chk("irq_unmasked", {31'd0, irq}, 32'd1);

        // 7: completion beats same-cycle acknowledge
        axi_write(4'h0, 32'h0, 4'hF, 1'b1, lat);
        axi_read(4'h4, 32'h2);
        chk("irq_done_wins", {31'd0, irq}, 32'd1);

        // start coinciding with completion is refused
        s0 = start_cnt;
        axi_write(4'h0, 32'h3, 4'hF, 1'b1, lat);
        chk("no_start_with_done", start_cnt - s0, 32'd0);
        chk("mode_frozen_on_err", {31'd0, core_mode}, 32'd0);
        axi_read(4'h4, 32'h6);
        axi_write(4'h4, 32'h6, 4'hF, 1'b0, lat);
        axi_read(4'h4, 32'h0);

        // reset mid-transaction
        s_axi.S_AXI_RREADY = 1'b0;
        s_axi.S_AXI_ARADDR = 4'hC; s_axi.S_AXI_ARVALID = 1'b1;
        s_axi.S_AXI_AWADDR = 4'h0; s_axi.S_AXI_AWVALID = 1'b1;
        step();
        s_axi.S_AXI_ARVALID = 1'b0; s_axi.S_AXI_AWVALID = 1'b0;
        step();
        chk("rvalid_pending", {31'd0, s_axi.S_AXI_RVALID}, 32'd1);
        tb_ARESET = 1'b1;
        #1;
        chk("reset_drops_valid", {29'd0, s_axi.S_AXI_RVALID, s_axi.S_AXI_BVALID, core_start}, 32'd0);
        step();
        tb_ARESET = 1'b0;
        s_axi.S_AXI_RREADY = 1'b1;
        step();
        chk("aw_freed_by_reset", {31'd0, s_axi.S_AXI_AWREADY}, 32'd1);
        axi_read(4'h8, 32'h1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
